// File: rtl/c3aibadapt_txdp_word_align_fsm_pkg.sv
// Shared definitions for the TX word-align monitor: state encodings,
// testbus field layout and the alternating marker reference pattern.
package c3aibadapt_wa_pkg;

    typedef enum logic [1:0] {
        WA_BYPASS = 2'b00,
        WA_SEARCH = 2'b01,
        WA_LOCKED = 2'b10
    } wa_state_e;

    // Testbus field layout (LSB positions)
    localparam int TB_WIDTH       = 20;
    localparam int TB_HIST_LSB    = 0;
    localparam int TB_HIST_W      = 9;
    localparam int TB_WM_BIT      = 9;
    localparam int TB_BAD_RUN_LSB = 10;
    localparam int TB_LOSS_BIT    = 14;
    localparam int TB_LOCK_BIT    = 15;
    localparam int TB_STATE_LSB   = 16;

    // Bit k set when the k-th most recent marker must be 1 (newest = bit 0)
    localparam logic [15:0] ALT_PATTERN = 16'h5555;

endpackage

// File: rtl/c3aibadapt_txdp_word_align_fsm_sat_cnt.sv
// Saturating up-counter with synchronous clear that wins over increment.
module c3aibadapt_wa_sat_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, stick at all-ones, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/c3aibadapt_txdp_word_align_fsm.sv
// TX word-align monitor: samples the per-word marker bit, acquires lock on an
// alternating marker sequence, tracks marker phase while locked, counts
// marker errors and optionally drops lock after a run of bad markers.
module c3aibadapt_txdp_word_align_fsm
    import c3aibadapt_wa_pkg::*;
#(
    parameter int DWIDTH      = 40,
    parameter int MARK_POS_HI = 39,
    parameter int MARK_POS_LO = 19,
    parameter int SEQ_LEN     = 6,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst_n,
    input  logic                 wr_srst_n,
    input  logic                 r_wa_en,
    input  logic                 r_relock_en,
    input  logic                 r_err_clr,
    input  logic [DWIDTH-1:0]    aib_hssi_tx_data_in,
    input  logic                 mark_bit_location,
    output logic                 wa_lock,
    output logic                 wa_loss_pulse,
    output logic [ERR_CNT_W-1:0] wa_err_cnt,
    output logic [TB_WIDTH-1:0]  word_align_testbus
);

    localparam logic [SEQ_LEN-1:0] HIT_PAT   = ALT_PATTERN[SEQ_LEN-1:0];
    localparam logic [3:0]         LOSS_LAST = 4'(LOSS_THRESH - 1);

    wa_state_e              state_q;
    wa_state_e              state_d;
    logic                   wm_bit;
    logic [SEQ_LEN-2:0]     hist;
    logic [SEQ_LEN-1:0]     window;
    logic                   exp_q;
    logic [3:0]             bad_run;
    logic                   marker_sel;
    logic                   hit;
    logic                   locked_active;
    logic                   mismatch;
    logic                   loss_d;
    logic                   bad_clr;
    logic                   err_clr;
    logic [TB_HIST_W-1:0]   hist_ext;
    logic                   unused_data;

    // Only the two marker positions matter; the payload is folded away
    assign unused_data   = ^aib_hssi_tx_data_in;

    assign marker_sel    = mark_bit_location ? aib_hssi_tx_data_in[MARK_POS_LO]
                                             : aib_hssi_tx_data_in[MARK_POS_HI];
    assign window        = {hist, wm_bit};
    assign hit           = wm_bit && (window == HIT_PAT);
    assign locked_active = (state_q == WA_LOCKED) && r_wa_en;
    assign mismatch      = locked_active && (wm_bit != exp_q);

    // Disabling word-align reports lock immediately, before the FSM moves
    assign wa_lock = (state_q == WA_LOCKED) || (state_q == WA_BYPASS) || !r_wa_en;

    // Next-state decode; loss_d flags the LOCKED->SEARCH drop
    always_comb begin
        state_d = state_q;
        loss_d  = 1'b0;
        if (!r_wa_en) begin
            state_d = WA_BYPASS;
        end else begin
            case (state_q)
                WA_BYPASS: state_d = WA_SEARCH;
                WA_SEARCH: if (hit) state_d = WA_LOCKED;
                WA_LOCKED: begin
                    if (mismatch && r_relock_en && (bad_run >= LOSS_LAST)) begin
                        state_d = WA_SEARCH;
                        loss_d  = 1'b1;
                    end
                end
                default:   state_d = WA_SEARCH;
            endcase
        end
    end

    // State register with both asynchronous and synchronous reset
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q <= WA_SEARCH;
        end else if (!wr_srst_n) begin
            state_q <= WA_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Marker capture, marker history, expected phase and loss pulse
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wm_bit        <= 1'b0;
            hist          <= '0;
            exp_q         <= 1'b0;
            wa_loss_pulse <= 1'b0;
        end else if (!wr_srst_n) begin
            wm_bit        <= 1'b0;
            hist          <= '0;
            exp_q         <= 1'b0;
            wa_loss_pulse <= 1'b0;
        end else begin
            wm_bit        <= marker_sel;
            wa_loss_pulse <= loss_d;
            if (!r_wa_en || (state_q == WA_BYPASS) || loss_d) begin
                hist <= '0;
            end else begin
                hist <= window[SEQ_LEN-2:0];
            end
            if (locked_active) begin
                exp_q <= !exp_q;
            end else if ((state_q == WA_SEARCH) && r_wa_en && hit) begin
                exp_q <= 1'b0;
            end
        end
    end

    assign bad_clr = !wr_srst_n || !r_wa_en || loss_d || (locked_active && !mismatch);
    assign err_clr = !wr_srst_n || r_err_clr;

    c3aibadapt_wa_sat_cnt #(.WIDTH(4)) u_bad_run (
        .clk   (wr_clk),
        .rst_n (wr_rst_n),
        .clr   (bad_clr),
        .inc   (mismatch),
        .count (bad_run)
    );

    c3aibadapt_wa_sat_cnt #(.WIDTH(ERR_CNT_W)) u_err_cnt (
        .clk   (wr_clk),
        .rst_n (wr_rst_n),
        .clr   (err_clr),
        .inc   (mismatch),
        .count (wa_err_cnt)
    );

    assign hist_ext = TB_HIST_W'(hist);

    // Pack the debug testbus from the live state fields
    always_comb begin
        word_align_testbus                              = '0;
        word_align_testbus[TB_STATE_LSB +: 2]           = state_q;
        word_align_testbus[TB_LOCK_BIT]                 = wa_lock;
        word_align_testbus[TB_LOSS_BIT]                 = wa_loss_pulse;
        word_align_testbus[TB_BAD_RUN_LSB +: 4]         = bad_run;
        word_align_testbus[TB_WM_BIT]                   = wm_bit;
        word_align_testbus[TB_HIST_LSB +: TB_HIST_W]    = hist_ext;
    end

endmodule
